// File: rtl/ex_unit_pkg.sv
// Shared definitions for the execute stage: opcode and result-class encodings,
// divide FSM states and common constants.
package ex_unit_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  typedef logic [7:0] aluop_t;
  typedef logic [2:0] alusel_t;

  localparam aluop_t EXE_NOP_OP   = 8'h00;
  localparam aluop_t EXE_AND_OP   = 8'h24;
  localparam aluop_t EXE_OR_OP    = 8'h25;
  localparam aluop_t EXE_XOR_OP   = 8'h26;
  localparam aluop_t EXE_NOR_OP   = 8'h27;
  localparam aluop_t EXE_SLL_OP   = 8'h7C;
  localparam aluop_t EXE_SRL_OP   = 8'h02;
  localparam aluop_t EXE_SRA_OP   = 8'h03;
  localparam aluop_t EXE_SLT_OP   = 8'h2A;
  localparam aluop_t EXE_SLTU_OP  = 8'h2B;
  localparam aluop_t EXE_ADD_OP   = 8'h20;
  localparam aluop_t EXE_ADDU_OP  = 8'h21;
  localparam aluop_t EXE_SUB_OP   = 8'h22;
  localparam aluop_t EXE_SUBU_OP  = 8'h23;
  localparam aluop_t EXE_MULT_OP  = 8'h18;
  localparam aluop_t EXE_MULTU_OP = 8'h19;
  localparam aluop_t EXE_DIV_OP   = 8'h1A;
  localparam aluop_t EXE_DIVU_OP  = 8'h1B;

  localparam alusel_t RES_NOP   = 3'b000;
  localparam alusel_t RES_LOGIC = 3'b001;
  localparam alusel_t RES_SHIFT = 3'b010;
  localparam alusel_t RES_ARITH = 3'b100;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DIV_ON   = 2'b01,
    DIV_ZERO = 2'b10,
    DIV_END  = 2'b11
  } div_state_e;

  function automatic logic is_div_op(input aluop_t op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_unit_div_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on operand
// magnitudes latched at start, with sign fix-up applied to the final result.
module div_iter
  import ex_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               busy
);

  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};

  div_state_e       state_r;
  div_state_e       state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvsr_r;
  logic             neg_quo_r;
  logic             neg_rem_r;
  logic [WIDTH-1:0] op1_mag_s;
  logic [WIDTH-1:0] op2_mag_s;
  logic             op2_zero_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   diff_s;
  logic             fits_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  assign op1_mag_s  = (signed_div && op1[WIDTH-1]) ? (~op1 + ONE_W) : op1;
  assign op2_mag_s  = (signed_div && op2[WIDTH-1]) ? (~op2 + ONE_W) : op2;
  assign op2_zero_s = (op2 == ZERO_W);

  // Partial remainder shifted left with the next dividend bit, then trial subtract.
  assign shifted_s = {rem_r, quo_r[WIDTH-1]};
  assign diff_s    = shifted_s - {1'b0, dvsr_r};
  assign fits_s    = (shifted_s >= {1'b0, dvsr_r});

  assign quo_fix_s = neg_quo_r ? (~quo_r + ONE_W) : quo_r;
  assign rem_fix_s = neg_rem_r ? (~rem_r + ONE_W) : rem_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    if (annul) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_next_s = op2_zero_s ? DIV_ZERO : DIV_ON;
          end else begin
            state_next_s = IDLE;
          end
        end
        DIV_ON: begin
          if (cnt_r == LAST_ITER) begin
            state_next_s = DIV_END;
          end else begin
            state_next_s = DIV_ON;
          end
        end
        DIV_ZERO: state_next_s = DIV_END;
        DIV_END:  state_next_s = IDLE;
        default:  state_next_s = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    ready  = 1'b0;
    busy   = 1'b0;
    result = {(2*WIDTH){1'b0}};
    case (state_r)
      DIV_ON, DIV_ZERO: busy = 1'b1;
      DIV_END: begin
        ready  = 1'b1;
        result = {rem_fix_s, quo_fix_s};
      end
      default: begin
        ready = 1'b0;
        busy  = 1'b0;
      end
    endcase
  end

  // Divide datapath: latch magnitudes and signs at start, then shift/subtract
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_r     <= {CNT_W{1'b0}};
      quo_r     <= ZERO_W;
      rem_r     <= ZERO_W;
      dvsr_r    <= ZERO_W;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
    end else if ((state_r == IDLE) && start && !annul) begin
      cnt_r     <= {CNT_W{1'b0}};
      quo_r     <= op2_zero_s ? ZERO_W : op1_mag_s;
      rem_r     <= ZERO_W;
      dvsr_r    <= op2_mag_s;
      neg_quo_r <= signed_div && !op2_zero_s && (op1[WIDTH-1] ^ op2[WIDTH-1]);
      neg_rem_r <= signed_div && !op2_zero_s && op1[WIDTH-1];
    end else if ((state_r == DIV_ON) && !annul) begin
      cnt_r <= cnt_r + CNT_ONE;
      if (fits_s) begin
        rem_r <= diff_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_r <= shifted_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/ex_unit.sv
// MIPS execute stage: single-cycle logic/shift/arith/compare/multiply units and
// an iterative divider that holds the pipeline through stallreq_o.
module ex_unit
  import ex_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int ALUSEL_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [ALUSEL_W-1:0]   alusel_i,
  input  logic [WIDTH-1:0]      reg1_i,
  input  logic [WIDTH-1:0]      reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [WIDTH-1:0]      wdata_o,
  output logic                  whilo_o,
  output logic [WIDTH-1:0]      hi_o,
  output logic [WIDTH-1:0]      lo_o,
  output logic                  stallreq_o
);

  localparam int               SHAMT_W = $clog2(WIDTH);
  localparam int               MSB     = WIDTH - 1;
  localparam logic [WIDTH-1:0] ZERO_W  = WIDTH'(ZeroWord);

  aluop_t               op_s;
  alusel_t              sel_s;
  logic [SHAMT_W-1:0]   shamt_s;
  logic [WIDTH-1:0]     logic_res_s;
  logic [WIDTH-1:0]     shift_res_s;
  logic [WIDTH-1:0]     arith_res_s;
  logic [WIDTH-1:0]     sel_res_s;
  logic [WIDTH-1:0]     sum_s;
  logic [WIDTH-1:0]     diff_s;
  logic                 add_ovf_s;
  logic                 sub_ovf_s;
  logic                 ovf_s;
  logic                 slt_s;
  logic                 sltu_s;
  logic                 is_mult_s;
  logic                 mul_signed_s;
  logic [2*WIDTH-1:0]   mul_a_s;
  logic [2*WIDTH-1:0]   mul_b_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic                 div_req_s;
  logic [2*WIDTH-1:0]   div_result_s;
  logic                 div_ready_s;
  logic                 div_busy_s;

  assign op_s    = aluop_t'(aluop_i);
  assign sel_s   = alusel_t'(alusel_i);
  assign shamt_s = reg1_i[SHAMT_W-1:0];

  assign sum_s     = reg1_i + reg2_i;
  assign diff_s    = reg1_i - reg2_i;
  assign add_ovf_s = (reg1_i[MSB] == reg2_i[MSB]) && (sum_s[MSB] != reg1_i[MSB]);
  assign sub_ovf_s = (reg1_i[MSB] != reg2_i[MSB]) && (diff_s[MSB] != reg1_i[MSB]);
  assign slt_s     = $signed(reg1_i) < $signed(reg2_i);
  assign sltu_s    = reg1_i < reg2_i;

  // One 2W-bit multiplier serves both forms: operands are sign- or zero-extended.
  assign is_mult_s    = (op_s == EXE_MULT_OP) || (op_s == EXE_MULTU_OP);
  assign mul_signed_s = (op_s == EXE_MULT_OP);
  assign mul_a_s      = {{WIDTH{mul_signed_s & reg1_i[MSB]}}, reg1_i};
  assign mul_b_s      = {{WIDTH{mul_signed_s & reg2_i[MSB]}}, reg2_i};
  assign prod_s       = mul_a_s * mul_b_s;

  assign div_req_s = is_div_op(op_s) && !flush_i;

  div_iter #(
    .WIDTH (WIDTH)
  ) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .start      (div_req_s),
    .signed_div (op_s == EXE_DIV_OP),
    .op1        (reg1_i),
    .op2        (reg2_i),
    .annul      (flush_i),
    .result     (div_result_s),
    .ready      (div_ready_s),
    .busy       (div_busy_s)
  );

  // Logic unit
  always_comb begin
    logic_res_s = ZERO_W;
    case (op_s)
      EXE_OR_OP:  logic_res_s = reg1_i | reg2_i;
      EXE_AND_OP: logic_res_s = reg1_i & reg2_i;
      EXE_XOR_OP: logic_res_s = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res_s = ~(reg1_i | reg2_i);
      default:    logic_res_s = ZERO_W;
    endcase
  end

  // Barrel shifter
  always_comb begin
    shift_res_s = ZERO_W;
    case (op_s)
      EXE_SLL_OP: shift_res_s = reg2_i << shamt_s;
      EXE_SRL_OP: shift_res_s = reg2_i >> shamt_s;
      EXE_SRA_OP: shift_res_s = $signed(reg2_i) >>> shamt_s;
      default:    shift_res_s = ZERO_W;
    endcase
  end

  // Adder, compare and overflow detection
  always_comb begin
    arith_res_s = ZERO_W;
    ovf_s       = 1'b0;
    case (op_s)
      EXE_ADD_OP: begin
        arith_res_s = sum_s;
        ovf_s       = add_ovf_s;
      end
      EXE_ADDU_OP: arith_res_s = sum_s;
      EXE_SUB_OP: begin
        arith_res_s = diff_s;
        ovf_s       = sub_ovf_s;
      end
      EXE_SUBU_OP: arith_res_s = diff_s;
      EXE_SLT_OP:  arith_res_s = {{(WIDTH-1){1'b0}}, slt_s};
      EXE_SLTU_OP: arith_res_s = {{(WIDTH-1){1'b0}}, sltu_s};
      default: begin
        arith_res_s = ZERO_W;
        ovf_s       = 1'b0;
      end
    endcase
  end

  // Result-class select
  always_comb begin
    sel_res_s = ZERO_W;
    case (sel_s)
      RES_LOGIC: sel_res_s = logic_res_s;
      RES_SHIFT: sel_res_s = shift_res_s;
      RES_ARITH: sel_res_s = arith_res_s;
      default:   sel_res_s = ZERO_W;
    endcase
  end

  // Stage outputs; everything is held at zero while reset is asserted
  always_comb begin
    wd_o       = {REG_ADDR_W{1'b0}};
    wreg_o     = 1'b0;
    wdata_o    = ZERO_W;
    whilo_o    = WriteDisable;
    hi_o       = ZERO_W;
    lo_o       = ZERO_W;
    stallreq_o = 1'b0;
    if (rst == RstEnable) begin
      stallreq_o = 1'b0;
    end else begin
      wd_o       = wd_i;
      wreg_o     = wreg_i & ~ovf_s;
      stallreq_o = (div_req_s && !div_ready_s) || div_busy_s;
      if (div_busy_s) begin
        wdata_o = ZERO_W;
      end else begin
        wdata_o = sel_res_s;
      end
      if (is_mult_s) begin
        whilo_o = WriteEnable;
        hi_o    = prod_s[2*WIDTH-1:WIDTH];
        lo_o    = prod_s[WIDTH-1:0];
      end else if (div_ready_s && !flush_i) begin
        whilo_o = WriteEnable;
        hi_o    = div_result_s[2*WIDTH-1:WIDTH];
        lo_o    = div_result_s[WIDTH-1:0];
      end else begin
        whilo_o = WriteDisable;
      end
    end
  end

endmodule

// File: tb/tb_ex_unit.sv
// Directed bench for ex_unit: expected results are queued when stimulus is
// driven and popped for comparison when the stage produces them.
module tb_ex_unit;
  import ex_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic [7:0]  aluop = 8'h00;
  logic [2:0]  alusel = 3'b000;
  logic [31:0] reg1 = 32'h0;
  logic [31:0] reg2 = 32'h0;
  logic [4:0]  wd = 5'd0;
  logic        wreg = 1'b0;
  logic [7:0]  aluop16 = 8'h00;
  logic [2:0]  alusel16 = 3'b000;
  logic [15:0] reg1_16 = 16'h0;
  logic [15:0] reg2_16 = 16'h0;

  logic [4:0]  wd_o, wd16;
  logic        wreg_o, wreg16, whilo_o, whilo16, stall_o, stall16;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic [15:0] wdata16, hi16, lo16;

  always #5 clk = ~clk;

  ex_unit u_dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stall_o)
  );

  ex_unit #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .flush_i(flush_i), .aluop_i(aluop16), .alusel_i(alusel16),
    .reg1_i(reg1_16), .reg2_i(reg2_16), .wd_i(wd), .wreg_i(wreg),
    .wd_o(wd16), .wreg_o(wreg16), .wdata_o(wdata16), .whilo_o(whilo16),
    .hi_o(hi16), .lo_o(lo16), .stallreq_o(stall16)
  );

  typedef struct {
    string       tag;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic        wreg;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic comb_op(input string tag, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b, input logic wr,
                         input logic [31:0] e_wdata, input logic [31:0] e_hi,
                         input logic [31:0] e_lo, input logic e_whilo, input logic e_wreg);
    exp_t e;
    @(negedge clk);
    e.tag = tag; e.wdata = e_wdata; e.hi = e_hi; e.lo = e_lo;
    e.whilo = e_whilo; e.wreg = e_wreg; e.stalls = 0;
    sb.push_back(e);
    aluop = op; alusel = sel; reg1 = a; reg2 = b; wreg = wr; wd = 5'd9;
    #1;
    e = sb.pop_front();
    chk(e.tag, 128'({stall_o, wreg_o, whilo_o, wdata_o, hi_o, lo_o}),
        128'({1'b0, e.wreg, e.whilo, e.wdata, e.hi, e.lo}));
  endtask

  task automatic run_div(input string tag, input bit w16, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b, input int e_stalls,
                         input logic [31:0] e_hi, input logic [31:0] e_lo);
    exp_t e;
    int   stalls = 0;
    int   junk = 0;
    bit   done = 1'b0;
    logic [31:0] obs_hi, obs_lo;
    @(negedge clk);
    e.tag = tag; e.wdata = 32'h0; e.hi = e_hi; e.lo = e_lo;
    e.whilo = 1'b1; e.wreg = 1'b0; e.stalls = e_stalls;
    sb.push_back(e);
    wreg = 1'b0;
    if (w16) begin
      aluop = EXE_NOP_OP; aluop16 = op; alusel16 = RES_NOP; reg1_16 = a[15:0]; reg2_16 = b[15:0];
    end else begin
      aluop = op; alusel = RES_NOP; reg1 = a; reg2 = b;
    end
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (w16 ? whilo16 : whilo_o) begin
        done = 1'b1;
      end else begin
        if (w16 ? stall16 : stall_o) stalls++;
        if ((w16 ? {16'h0, wdata16} : wdata_o) != 32'h0) junk++;
        @(negedge clk);
      end
    end
    obs_hi = w16 ? {16'h0, hi16} : hi_o;
    obs_lo = w16 ? {16'h0, lo16} : lo_o;
    e = sb.pop_front();
    chk({e.tag, " reached DIV_END"}, 128'(done), 128'(1'b1));
    chk({e.tag, " stall cycles"}, 128'(stalls), 128'(e.stalls));
    chk({e.tag, " hi/lo/whilo"}, 128'({obs_hi, obs_lo, done}), 128'({e.hi, e.lo, e.whilo}));
    chk({e.tag, " stall at DIV_END"}, 128'(w16 ? stall16 : stall_o), 128'(1'b0));
    chk({e.tag, " wdata while stalled"}, 128'(junk), 128'(0));
  endtask

  task automatic abort_div(input string tag, input bit use_rst);
    int pulses = 0;
    @(negedge clk);
    aluop = EXE_DIV_OP; alusel = RES_NOP; reg1 = 32'd1000; reg2 = 32'd3; wreg = 1'b0;
    repeat (10) begin
      #1; if (whilo_o) pulses++;
      @(negedge clk);
    end
    if (use_rst) rst = 1'b1; else flush_i = 1'b1;
    #1;
    if (whilo_o) pulses++;
    if (use_rst)
      chk({tag, " outputs during reset"},
          128'({wd_o, wreg_o, whilo_o, stall_o, wdata_o, hi_o, lo_o}), 128'(0));
    @(negedge clk);
    rst = 1'b0; flush_i = 1'b0; aluop = EXE_NOP_OP;
    #1;
    chk({tag, " stall after abort"}, 128'(stall_o), 128'(1'b0));
    repeat (40) begin
      if (whilo_o) pulses++;
      @(negedge clk); #1;
    end
    chk({tag, " no HI/LO write"}, 128'(pulses), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    // Reset: all outputs zero even with live operands presented
    aluop = EXE_OR_OP; alusel = RES_LOGIC; reg1 = 32'hFFFF_0000; reg2 = 32'h1234;
    wd = 5'd7; wreg = 1'b1;
    @(negedge clk); #1;
    chk("reset outputs", 128'({wd_o, wreg_o, whilo_o, stall_o, wdata_o, hi_o, lo_o}), 128'(0));
    aluop = EXE_MULT_OP; reg1 = 32'hFFFF_FFFE; reg2 = 32'd3;
    @(negedge clk); #1;
    chk("reset mult outputs", 128'({whilo_o, hi_o, lo_o}), 128'(0));
    chk("reset outputs w16", 128'({wd16, wreg16, whilo16, stall16, wdata16, hi16, lo16}), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    comb_op("OR", EXE_OR_OP, RES_LOGIC, 32'h0F0F_0000, 32'h0000_00FF, 1'b1,
            32'h0F0F_00FF, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("wd pass-through", 128'(wd_o), 128'(5'd9));
    comb_op("SRA", EXE_SRA_OP, RES_SHIFT, 32'd4, 32'h8000_0000, 1'b1,
            32'hF800_0000, 32'h0, 32'h0, 1'b0, 1'b1);
    comb_op("SRL shamt low bits", EXE_SRL_OP, RES_SHIFT, 32'h24, 32'h8000_0000, 1'b1,
            32'h0800_0000, 32'h0, 32'h0, 1'b0, 1'b1);
    comb_op("SLL by 31", EXE_SLL_OP, RES_SHIFT, 32'd31, 32'h1, 1'b1,
            32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b1);
    comb_op("NOR", EXE_NOR_OP, RES_LOGIC, 32'hF0F0_0000, 32'h0000_000F, 1'b1,
            32'h0F0F_FFF0, 32'h0, 32'h0, 1'b0, 1'b1);
    comb_op("SLT", EXE_SLT_OP, RES_ARITH, 32'hFFFF_FFFF, 32'h1, 1'b1,
            32'h1, 32'h0, 32'h0, 1'b0, 1'b1);
    comb_op("SLTU", EXE_SLTU_OP, RES_ARITH, 32'hFFFF_FFFF, 32'h1, 1'b1,
            32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    comb_op("MULT", EXE_MULT_OP, RES_NOP, 32'hFFFF_FFFE, 32'd3, 1'b0,
            32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, 1'b0);
    comb_op("MULTU", EXE_MULTU_OP, RES_NOP, 32'hFFFF_FFFF, 32'd2, 1'b0,
            32'h0, 32'h1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    comb_op("ADD overflow", EXE_ADD_OP, RES_ARITH, 32'h7FFF_FFFF, 32'h1, 1'b1,
            32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0);
    comb_op("ADDU no trap", EXE_ADDU_OP, RES_ARITH, 32'h7FFF_FFFF, 32'h1, 1'b1,
            32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b1);
    comb_op("SUB overflow", EXE_SUB_OP, RES_ARITH, 32'h8000_0000, 32'h1, 1'b1,
            32'h7FFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b0);
    comb_op("SUB in range", EXE_SUB_OP, RES_ARITH, 32'h0000_0005, 32'h0000_0007, 1'b1,
            32'hFFFF_FFFE, 32'h0, 32'h0, 1'b0, 1'b1);
    comb_op("unknown op", 8'hFF, RES_LOGIC, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1,
            32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    comb_op("class none", EXE_OR_OP, RES_NOP, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1,
            32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      case (i % 3)
        0: comb_op("rand ADDU", EXE_ADDU_OP, RES_ARITH, a, b, 1'b1, a + b, 32'h0, 32'h0, 1'b0, 1'b1);
        1: comb_op("rand XOR", EXE_XOR_OP, RES_LOGIC, a, b, 1'b1, a ^ b, 32'h0, 32'h0, 1'b0, 1'b1);
        default: comb_op("rand SUBU", EXE_SUBU_OP, RES_ARITH, a, b, 1'b1, a - b, 32'h0, 32'h0, 1'b0, 1'b1);
      endcase
    end

    run_div("DIV -7/2", 1'b0, EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div("DIVU 100/7", 1'b0, EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_div("DIV MIN/-1", 1'b0, EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
    run_div("DIV 7/-2", 1'b0, EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
    run_div("DIVU 5/0", 1'b0, EXE_DIVU_OP, 32'd5, 32'd0, 2, 32'h0, 32'h0);

    abort_div("flush abort", 1'b0);
    abort_div("reset abort", 1'b1);
    run_div("DIVU after abort", 1'b0, EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd16, 33, 32'd15, 32'h0FFF_FFFF);

    run_div("W16 DIVU FFFF/3", 1'b1, EXE_DIVU_OP, 32'h0000_FFFF, 32'd3, 17, 32'h0, 32'h5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
